// File: rtl/mul_div_exec_unit.sv
// ----------------------------------------------------------------------------
// mul_div_exec_unit
//
// RV32M execution unit fed by the mul/div reservation queue. One operation is
// in flight at a time. Multiplies (MUL/MULH/MULHSU/MULHU) complete after a fixed
// MUL_LAT cycles in the MUL state. Divides (DIV/DIVU/REM/REMU) run a radix-2
// restoring divider for 32 cycles; divide-by-zero and signed overflow resolve
// at issue and skip the divider. Results are published on the CDB through a
// request/grant handshake. If the destination tag is not valid, the unit only
// retires the op.
//
// Ports
//   clk           clock
//   rst           synchronous reset, active low
//   issue_valid   queue presents a ready entry (sampled only in IDLE)
//   op1_data      rs1 value
//   op2_data      rs2 value
//   funct3        RV32M funct3
//   rd_tag        destination tag
//   rd_tag_valid  destination tag valid
//   ex_done       1-cycle pulse: op retired, queue may drop its entry
//   busy          unit not in IDLE
//   cdb_req       CDB slot request (DONE with a valid tag)
//   cdb_grant     arbiter grant, same cycle
//   cdb_valid     CDB publish strobe
//   cdb_tag       published tag (0 when cdb_valid=0)
//   cdb_data      published result (0 when cdb_valid=0)
// ----------------------------------------------------------------------------
module mul_div_exec_unit #(
    parameter int MUL_LAT = 3,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [XLEN-1:0] op1_data,
    input  logic [XLEN-1:0] op2_data,
    input  logic [2:0]      funct3,
    input  logic [5:0]      rd_tag,
    input  logic            rd_tag_valid,
    output logic            ex_done,
    output logic            busy,
    output logic            cdb_req,
    input  logic            cdb_grant,
    output logic            cdb_valid,
    output logic [5:0]      cdb_tag,
    output logic [XLEN-1:0] cdb_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [1:0]      r_f3;         // funct3[2] only selects the path; low bits pick the variant
    logic [5:0]      r_tag;
    logic            r_tag_valid;
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;        // holds the dividend magnitude, shifted out as quotient bits come in
    logic [XLEN-1:0] r_dvs;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_result;

    // ------------------------------------------------------------------------
    // Issue-time decode (operates on the queue's operands)
    // ------------------------------------------------------------------------
    logic            w_issue_div;
    logic            w_issue_signed;
    logic            w_div_by_zero;
    logic            w_div_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_op1_neg;
    logic            w_op2_neg;
    logic [XLEN-1:0] w_op1_mag;
    logic [XLEN-1:0] w_op2_mag;

    assign w_issue_div    = funct3[2];
    assign w_issue_signed = ~funct3[0];
    assign w_div_by_zero  = (op2_data == '0);
    assign w_div_ovf      = w_issue_signed && (op1_data == {1'b1, {(XLEN-1){1'b0}}})
                            && (op2_data == '1);
    assign w_special      = w_issue_div && (w_div_by_zero || w_div_ovf);

    // REM variants: op1 on /0, 0 on overflow. DIV variants: all ones on /0,
    // the most negative value on overflow.
    always_comb begin
        if (funct3[1]) begin
            w_special_res = w_div_by_zero ? op1_data : '0;
        end else begin
            w_special_res = w_div_by_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    assign w_op1_neg = w_issue_signed && op1_data[XLEN-1];
    assign w_op2_neg = w_issue_signed && op2_data[XLEN-1];
    assign w_op1_mag = w_op1_neg ? (~op1_data + 1'b1) : op1_data;
    assign w_op2_mag = w_op2_neg ? (~op2_data + 1'b1) : op2_data;

    // ------------------------------------------------------------------------
    // Multiplier: operands are held for the whole MUL stay, so the product
    // has MUL_LAT cycles to settle before it is captured on the last one.
    // Extended operands are 33-bit; the true product always fits in 64 bits
    // (the two top bits of the full 66-bit result are sign copies).
    // ------------------------------------------------------------------------
    logic signed [XLEN:0]     w_mul_a;
    logic signed [XLEN:0]     w_mul_b;
    logic signed [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]          w_mul_res;

    assign w_mul_a   = {((r_f3 == 2'b01) || (r_f3 == 2'b10)) && r_op1[XLEN-1], r_op1};
    assign w_mul_b   = {(r_f3 == 2'b01) && r_op2[XLEN-1], r_op2};
    assign w_prod    = w_mul_a * w_mul_b;
    assign w_mul_res = (r_f3 == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    // ------------------------------------------------------------------------
    // Restoring divider step: one quotient bit per cycle
    // ------------------------------------------------------------------------
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_fits;
    logic [XLEN-1:0] w_rem_nx;
    logic [XLEN-1:0] w_quo_nx;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;
    logic [XLEN-1:0] w_div_res;

    assign w_shift   = {r_rem, r_quo[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_fits    = ~w_diff[XLEN];
    assign w_rem_nx  = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_quo_nx  = {r_quo[XLEN-2:0], w_fits};
    // Sign fixup applied to the final step's values on the DIV->DONE edge
    assign w_q_fix   = r_neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx;
    assign w_r_fix   = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;
    assign w_div_res = r_f3[1] ? w_r_fix : w_q_fix;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and outputs. Handshake outputs are qualified by rst so a
    // reset cycle never retires or publishes the op being discarded.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        ex_done   = 1'b0;
        cdb_req   = 1'b0;
        cdb_valid = 1'b0;
        cdb_tag   = '0;
        cdb_data  = '0;
        busy      = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (issue_valid) begin
                    if (!w_issue_div) begin
                        w_next = S_MUL;
                    end else if (w_special) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_DIV;
                    end
                end
            end
            S_MUL: begin
                if (r_cnt == '0) begin
                    w_next = S_DONE;
                end
            end
            S_DIV: begin
                if (r_cnt == '0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (r_tag_valid) begin
                    cdb_req = rst;
                    if (cdb_grant) begin
                        cdb_valid = rst;
                        ex_done   = rst;
                        w_next    = S_IDLE;
                    end
                end else begin
                    ex_done = rst;
                    w_next  = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        if (cdb_valid) begin
            cdb_tag  = r_tag;
            cdb_data = r_result;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op1       <= '0;
            r_op2       <= '0;
            r_f3        <= '0;
            r_tag       <= '0;
            r_tag_valid <= 1'b0;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (issue_valid) begin
                        r_op1       <= op1_data;
                        r_op2       <= op2_data;
                        r_f3        <= funct3[1:0];
                        r_tag       <= rd_tag;
                        r_tag_valid <= rd_tag_valid;
                        r_neg_q     <= w_op1_neg ^ w_op2_neg;
                        r_neg_r     <= w_op1_neg;
                        r_rem       <= '0;
                        r_quo       <= w_op1_mag;
                        r_dvs       <= w_op2_mag;
                        r_cnt       <= w_issue_div ? 5'd31 : 5'(MUL_LAT - 1);
                        r_result    <= w_special ? w_special_res : '0;
                    end
                end
                S_MUL: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_result <= w_mul_res;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_result <= w_div_res;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_mul_div_exec_unit
//
// Directed vectors for mul_div_exec_unit. A behavioural model computes each
// op's result with plain 64-bit arithmetic and its latency from the op class.
// A negedge compare process checks every handshake output on every cycle,
// and checks published data against hand-computed literals.
// ----------------------------------------------------------------------------
module tb_mul_div_exec_unit;

    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic [31:0] op1_data = '0;
    logic [31:0] op2_data = '0;
    logic [2:0]  funct3 = '0;
    logic [5:0]  rd_tag = '0;
    logic        rd_tag_valid = 1'b0;
    logic        cdb_grant = 1'b0;
    logic        ex_done;
    logic        busy;
    logic        cdb_req;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;

    mul_div_exec_unit #(.MUL_LAT(MUL_LAT), .XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .op1_data     (op1_data),
        .op2_data     (op2_data),
        .funct3       (funct3),
        .rd_tag       (rd_tag),
        .rd_tag_valid (rd_tag_valid),
        .ex_done      (ex_done),
        .busy         (busy),
        .cdb_req      (cdb_req),
        .cdb_grant    (cdb_grant),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model of the op in flight (written only by the driver)
    bit          m_active = 1'b0;
    int          m_start = 0;
    int          m_lat = 0;
    logic [5:0]  m_tag = '0;
    bit          m_tv = 1'b0;
    logic [31:0] m_data = '0;
    logic [31:0] m_lit = '0;
    bit          m_has_lit = 1'b0;
    bit          chk_en = 1'b0;
    int          tmo_cnt = 0;

    // Written only by the compare process
    int errors = 0;
    int checks = 0;
    int retire_cnt = 0;
    int tmo_seen = 0;

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      p;
        logic [63:0] pv;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            3'd0: begin p = sa * sb; pv = p; return pv[31:0]; end
            3'd1: begin p = sa * sb; pv = p; return pv[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); pv = p; return pv[63:32]; end
            3'd3: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
            default: begin
                if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
                if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return f3[1] ? 32'd0 : 32'h8000_0000;
                if (!f3[0]) begin
                    p = f3[1] ? (sa % sb) : (sa / sb);
                    pv = p;
                    return pv[31:0];
                end
                u = f3[1] ? ({32'b0, a} % {32'b0, b}) : ({32'b0, a} / {32'b0, b});
                return u[31:0];
            end
        endcase
    endfunction

    // Cycles from the issue cycle to the first DONE cycle
    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return MUL_LAT + 1;
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Compare process
    logic        e_busy, e_in_done, e_req, e_valid, e_exd;
    logic [5:0]  e_tag;
    logic [31:0] e_data;
    always @(negedge clk) begin
        if (chk_en) begin
            e_busy    = m_active && (cyc > m_start);
            e_in_done = m_active && (cyc >= m_start + m_lat);
            e_req     = e_in_done && m_tv && rst;
            e_valid   = e_req && cdb_grant;
            e_exd     = e_in_done && rst && (m_tv ? cdb_grant : 1'b1);
            e_tag     = e_valid ? m_tag : 6'd0;
            e_data    = e_valid ? m_data : 32'd0;
            chk("busy",      {31'b0, busy},      {31'b0, e_busy});
            chk("cdb_req",   {31'b0, cdb_req},   {31'b0, e_req});
            chk("cdb_valid", {31'b0, cdb_valid}, {31'b0, e_valid});
            chk("ex_done",   {31'b0, ex_done},   {31'b0, e_exd});
            chk("cdb_tag",   {26'b0, cdb_tag},   {26'b0, e_tag});
            chk("cdb_data",  cdb_data,           e_data);
            if (e_valid && m_has_lit) begin
                chk("lit_dut",   cdb_data, m_lit);
                chk("lit_model", m_data,   m_lit);
            end
            if (e_exd) retire_cnt++;
            if (tmo_cnt != tmo_seen) begin
                tmo_seen = tmo_cnt;
                checks++;
                errors++;
                $display("FAIL timeout cyc=%0d got=no_retire expected=retire", cyc);
            end
        end
    end

    // Issue one op and hold the entry until retirement; stall>0 withholds
    // grant for that many DONE cycles, stall=0 ties grant high.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] tag, input bit tv, input int stall,
                          input bit has_lit, input logic [31:0] lit);
        int r0;
        int n;
        funct3       = f3;
        op1_data     = a;
        op2_data     = b;
        rd_tag       = tag;
        rd_tag_valid = tv;
        issue_valid  = 1'b1;
        m_tag        = tag;
        m_tv         = tv;
        m_data       = ref_result(f3, a, b);
        m_lit        = lit;
        m_has_lit    = has_lit;
        m_lat        = ref_lat(f3, a, b);
        m_start      = cyc;
        m_active     = 1'b1;
        cdb_grant    = (stall == 0);
        r0 = retire_cnt;
        n  = 0;
        while (retire_cnt == r0 && n < 200) begin
            @(posedge clk); #1;
            n++;
            cdb_grant = (stall == 0) || (cyc >= m_start + m_lat + stall);
        end
        if (retire_cnt == r0) tmo_cnt++;
        issue_valid = 1'b0;
        m_active    = 1'b0;
        cdb_grant   = 1'b0;
    endtask

    // Issue an op and pull reset 'at' cycles later
    task automatic run_rst(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] tag, input int at);
        funct3       = f3;
        op1_data     = a;
        op2_data     = b;
        rd_tag       = tag;
        rd_tag_valid = 1'b1;
        issue_valid  = 1'b1;
        m_tag        = tag;
        m_tv         = 1'b1;
        m_data       = ref_result(f3, a, b);
        m_has_lit    = 1'b0;
        m_lat        = ref_lat(f3, a, b);
        m_start      = cyc;
        m_active     = 1'b1;
        cdb_grant    = 1'b1;
        repeat (at) begin @(posedge clk); #1; end
        rst         = 1'b0;
        issue_valid = 1'b0;
        @(posedge clk); #1;
        rst       = 1'b1;
        m_active  = 1'b0;
        cdb_grant = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b1;
        chk_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Multiplies
        run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 6'h15, 1'b1, 0, 1'b1, 32'hFFFF_FFEB);
        run_op(3'b001, 32'h8000_0000,  32'h8000_0000, 6'h01, 1'b1, 0, 1'b1, 32'h4000_0000);
        run_op(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 6'h02, 1'b1, 0, 1'b1, 32'hFFFF_FFFE);
        run_op(3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 6'h03, 1'b1, 0, 1'b1, 32'hFFFF_FFFF);
        run_op(3'b001, 32'hFFFF_FFFE,  32'd3,         6'h04, 1'b1, 0, 1'b1, 32'hFFFF_FFFF);
        // Signed / unsigned divides
        run_op(3'b100, 32'hFFFF_FFEC,  32'd3,         6'h05, 1'b1, 0, 1'b1, 32'hFFFF_FFFA);
        run_op(3'b110, 32'hFFFF_FFEC,  32'd3,         6'h06, 1'b1, 0, 1'b1, 32'hFFFF_FFFE);
        run_op(3'b100, 32'd20,         32'hFFFF_FFFD, 6'h07, 1'b1, 0, 1'b1, 32'hFFFF_FFFA);
        run_op(3'b110, 32'd20,         32'hFFFF_FFFD, 6'h08, 1'b1, 0, 1'b1, 32'd2);
        run_op(3'b101, 32'd100,        32'd7,         6'h09, 1'b1, 0, 1'b1, 32'd14);
        run_op(3'b111, 32'd100,        32'd7,         6'h0A, 1'b1, 0, 1'b1, 32'd2);
        run_op(3'b101, 32'hFFFF_FFFF,  32'd1,         6'h0B, 1'b1, 0, 1'b1, 32'hFFFF_FFFF);
        // Special cases
        run_op(3'b100, 32'd5,          32'd0,         6'h0C, 1'b1, 0, 1'b1, 32'hFFFF_FFFF);
        run_op(3'b110, 32'd5,          32'd0,         6'h0D, 1'b1, 0, 1'b1, 32'd5);
        run_op(3'b111, 32'h1234_5678,  32'd0,         6'h0E, 1'b1, 0, 1'b1, 32'h1234_5678);
        run_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 6'h0F, 1'b1, 0, 1'b1, 32'h8000_0000);
        run_op(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 6'h10, 1'b1, 0, 1'b1, 32'd0);
        run_op(3'b101, 32'h8000_0000,  32'hFFFF_FFFF, 6'h11, 1'b1, 0, 1'b1, 32'd0);
        // Grant stall, then no-tag retire
        run_op(3'b000, 32'h0001_2345,  32'h10,        6'h2A, 1'b1, 5, 1'b1, 32'h0012_3450);
        run_op(3'b101, 32'd50,         32'd5,         6'h2B, 1'b1, 3, 1'b1, 32'd10);
        run_op(3'b000, 32'd9,          32'd9,         6'h3F, 1'b0, 0, 1'b0, 32'd0);
        run_op(3'b100, 32'd9,          32'd0,         6'h3E, 1'b0, 0, 1'b0, 32'd0);
        // Reset mid-divide, then a clean op
        run_rst(3'b100, 32'd1000,      32'd7,         6'h20, 10);
        run_op(3'b101, 32'd1000,       32'd10,        6'h21, 1'b1, 0, 1'b1, 32'd100);
        run_op(3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 6'h22, 1'b1, 0, 1'b1, 32'd1);

        repeat (2) begin @(posedge clk); #1; end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
